// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive-path timing blocks.
package uart_rx_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    localparam int MIN_PRESCALE = 4;

    localparam logic [1:0] SMP_EARLY = 2'd0;
    localparam logic [1:0] SMP_MID   = 2'd1;
    localparam logic [1:0] SMP_LATE  = 2'd2;

endpackage

// File: rtl/uart_rx_sample_point_dec.sv
// Decodes the three mid-bit majority-vote sample points from an edge index.
// Purely combinational; the caller qualifies the strobe with its own activity.
module uart_rx_sample_point_dec
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = 6
) (
    input  logic [PRESCALE_W-1:0] edge_count,
    input  logic [PRESCALE_W-1:0] prescale_q,
    output logic                  sample_stb,
    output logic [1:0]            sample_idx
);

    localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

    logic [PRESCALE_W-1:0] mid;

    assign mid = prescale_q >> 1;

    always_comb begin
        sample_stb = 1'b0;
        sample_idx = SMP_EARLY;
        if (edge_count == mid - ONE) begin
            sample_stb = 1'b1;
            sample_idx = SMP_EARLY;
        end else if (edge_count == mid) begin
            sample_stb = 1'b1;
            sample_idx = SMP_MID;
        end else if (edge_count == mid + ONE) begin
            sample_stb = 1'b1;
            sample_idx = SMP_LATE;
        end
    end

endmodule

// File: rtl/uart_rx_frame_timer.sv
// Oversampling edge/bit counter for the UART RX path with sample strobes and
// bit/frame completion pulses; configuration is frozen for the whole frame.
module uart_rx_frame_timer
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = 6,
    parameter int BIT_CNT_W  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  count_en,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [BIT_CNT_W-1:0]  frame_bits,
    output logic [PRESCALE_W-1:0] edge_count,
    output logic [BIT_CNT_W-1:0]  bit_count,
    output logic                  sample_stb,
    output logic [1:0]            sample_idx,
    output logic                  bit_done,
    output logic                  frame_done,
    output logic                  busy,
    output logic                  cfg_err
);

    localparam logic [PRESCALE_W-1:0] ONE_E = PRESCALE_W'(1);
    localparam logic [BIT_CNT_W-1:0]  ONE_B = BIT_CNT_W'(1);

    state_t                  state;
    logic [PRESCALE_W-1:0]   prescale_q;
    logic [BIT_CNT_W-1:0]    frame_bits_q;

    logic                    cfg_ok;
    logic                    active;
    logic                    last_edge;
    logic                    last_bit;
    logic                    dec_stb;
    logic [1:0]              dec_idx;

    assign cfg_ok    = (prescale >= PRESCALE_W'(MIN_PRESCALE)) && (frame_bits != '0);
    assign active    = (state == COUNT) && count_en;
    assign last_edge = (edge_count == prescale_q - ONE_E);
    assign last_bit  = (bit_count == frame_bits_q - ONE_B);

    uart_rx_sample_point_dec #(
        .PRESCALE_W (PRESCALE_W)
    ) u_sample_dec (
        .edge_count (edge_count),
        .prescale_q (prescale_q),
        .sample_stb (dec_stb),
        .sample_idx (dec_idx)
    );

    // Pulses are gated by count_en so an abort cycle never reports a sample or completion.
    assign sample_stb = active && dec_stb;
    assign sample_idx = sample_stb ? dec_idx : SMP_EARLY;
    assign bit_done   = active && last_edge;
    assign frame_done = bit_done && last_bit;
    assign busy       = (state == COUNT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            edge_count   <= '0;
            bit_count    <= '0;
            prescale_q   <= '0;
            frame_bits_q <= '0;
            cfg_err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    edge_count <= '0;
                    bit_count  <= '0;
                    if (count_en) begin
                        if (cfg_ok) begin
                            prescale_q   <= prescale;
                            frame_bits_q <= frame_bits;
                            cfg_err      <= 1'b0;
                            state        <= COUNT;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                COUNT: begin
                    if (!count_en) begin
                        state      <= IDLE;
                        edge_count <= '0;
                        bit_count  <= '0;
                    end else if (last_edge) begin
                        edge_count <= '0;
                        if (last_bit) begin
                            state     <= IDLE;
                            bit_count <= '0;
                        end else begin
                            bit_count <= bit_count + ONE_B;
                        end
                    end else begin
                        edge_count <= edge_count + ONE_E;
                    end
                end
                default: begin
                    state      <= IDLE;
                    edge_count <= '0;
                    bit_count  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_timer.sv
// Self-checking bench for uart_rx_frame_timer: directed frames with literal timing
// expectations plus randomized traffic checked every cycle against a frame-time model.
module tb_uart_rx_frame_timer;

    logic       clk;
    logic       reset;
    logic       count_en;
    logic [5:0] prescale;
    logic [3:0] frame_bits;
    logic [5:0] edge_count;
    logic [3:0] bit_count;
    logic       sample_stb;
    logic [1:0] sample_idx;
    logic       bit_done;
    logic       frame_done;
    logic       busy;
    logic       cfg_err;

    int checks = 0;
    int errors = 0;

    uart_rx_frame_timer #(
        .PRESCALE_W (6),
        .BIT_CNT_W  (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .count_en   (count_en),
        .prescale   (prescale),
        .frame_bits (frame_bits),
        .edge_count (edge_count),
        .bit_count  (bit_count),
        .sample_stb (sample_stb),
        .sample_idx (sample_idx),
        .bit_done   (bit_done),
        .frame_done (frame_done),
        .busy       (busy),
        .cfg_err    (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            if (errors <= 40)
                $display("[TB] FAIL %s actual=%0d expected=%0d at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Inputs change just after the falling edge and hold through the next rising edge.
    task automatic applyStimulus(input logic r, input logic e, input logic [5:0] p, input logic [3:0] f);
        @(negedge clk);
        #1;
        reset      = r;
        count_en   = e;
        prescale   = p;
        frame_bits = f;
    endtask

    // The model views a frame as a single running time m_t since the first counted edge.
    bit m_busy = 1'b0;
    bit m_err  = 1'b0;
    int m_t    = 0;
    int m_p    = 0;
    int m_n    = 0;

    initial begin : compare_proc
        int e_edge, e_bit, e_idx, mid;
        bit run, e_stb, e_bd, e_fd;
        forever begin
            @(negedge clk);
            #3;
            e_edge = m_busy ? (m_t % m_p) : 0;
            e_bit  = m_busy ? (m_t / m_p) : 0;
            run    = m_busy && count_en;
            mid    = m_busy ? (m_p / 2) : 0;
            e_stb  = run && (e_edge >= mid - 1) && (e_edge <= mid + 1);
            e_idx  = e_stb ? (e_edge - (mid - 1)) : 0;
            e_bd   = run && (e_edge == m_p - 1);
            e_fd   = e_bd && (e_bit == m_n - 1);

            checkOutput("model_edge_count", edge_count, e_edge);
            checkOutput("model_bit_count", bit_count, e_bit);
            checkOutput("model_sample_stb", sample_stb, e_stb);
            checkOutput("model_sample_idx", sample_idx, e_idx);
            checkOutput("model_bit_done", bit_done, e_bd);
            checkOutput("model_frame_done", frame_done, e_fd);
            checkOutput("model_busy", busy, m_busy);
            checkOutput("model_cfg_err", cfg_err, m_err);

            if (reset) begin
                m_busy = 1'b0;
                m_err  = 1'b0;
                m_t    = 0;
            end else if (!m_busy) begin
                if (count_en) begin
                    if (prescale >= 4 && frame_bits >= 1) begin
                        m_busy = 1'b1;
                        m_t    = 0;
                        m_p    = prescale;
                        m_n    = frame_bits;
                        m_err  = 1'b0;
                    end else begin
                        m_err = 1'b1;
                    end
                end
            end else if (!count_en) begin
                m_busy = 1'b0;
                m_t    = 0;
            end else if (m_t + 1 == m_p * m_n) begin
                m_busy = 1'b0;
                m_t    = 0;
            end else begin
                m_t = m_t + 1;
            end
        end
    end

    // Holds inputs (optionally swapping prescale once bit change_bit is reached) until frame_done.
    task automatic runFrame(input int limit, input int change_bit, input logic [5:0] new_ps,
                            input int exp_mid, output int fd_cycle, output int n_bd);
        logic [5:0] p;
        fd_cycle = -1;
        n_bd     = 0;
        for (int k = 1; k <= limit; k++) begin
            p = prescale;
            if (change_bit >= 0 && int'(bit_count) >= change_bit)
                p = new_ps;
            applyStimulus(1'b0, count_en, p, frame_bits);
            #2;
            if (bit_done)
                n_bd++;
            if (sample_stb)
                checkOutput("stb_edge_position", edge_count, exp_mid - 1 + sample_idx);
            if (frame_done) begin
                fd_cycle = k;
                break;
            end
        end
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("[TB] FAIL watchdog expired before the bench completed");
        $fatal(1, "[TB] watchdog");
    end

    initial begin : main
        int fd, nbd, found;
        reset      = 1'b1;
        count_en   = 1'b0;
        prescale   = 6'd0;
        frame_bits = 4'd0;

        applyStimulus(1'b1, 1'b0, 6'd0, 4'd0);
        applyStimulus(1'b0, 1'b0, 6'd0, 4'd0);
        #2;
        checkOutput("reset_edge_count", edge_count, 0);
        checkOutput("reset_bit_count", bit_count, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_cfg_err", cfg_err, 0);
        checkOutput("reset_sample_stb", sample_stb, 0);

        $display("[TB] prescale=8 frame_bits=10 single frame");
        applyStimulus(1'b0, 1'b1, 6'd8, 4'd10);
        runFrame(200, -1, 6'd0, 4, fd, nbd);
        checkOutput("p8_frame_done_cycle", fd, 80);
        checkOutput("p8_bit_done_count", nbd, 10);
        applyStimulus(1'b0, 1'b0, 6'd8, 4'd10);
        #2;
        checkOutput("p8_busy_cycle81", busy, 0);

        $display("[TB] prescale=16 frame_bits=11 back-to-back frames");
        applyStimulus(1'b0, 1'b1, 6'd16, 4'd11);
        runFrame(400, -1, 6'd0, 8, fd, nbd);
        checkOutput("p16_first_frame_done", fd, 176);
        checkOutput("p16_bit_done_count", nbd, 11);
        applyStimulus(1'b0, 1'b1, 6'd16, 4'd11);
        #2;
        checkOutput("p16_gap_busy", busy, 0);
        runFrame(400, -1, 6'd0, 8, fd, nbd);
        checkOutput("p16_second_frame_done", 177 + fd, 353);
        applyStimulus(1'b0, 1'b0, 6'd16, 4'd11);

        $display("[TB] prescale change mid-frame");
        applyStimulus(1'b0, 1'b1, 6'd32, 4'd10);
        runFrame(600, 2, 6'd8, 16, fd, nbd);
        checkOutput("cfgchg_frame_done", fd, 320);
        checkOutput("cfgchg_bit_done_count", nbd, 10);
        applyStimulus(1'b0, 1'b0, 6'd8, 4'd10);

        $display("[TB] abort at bit 4 edge 7");
        applyStimulus(1'b0, 1'b1, 6'd16, 4'd10);
        found = 0;
        for (int k = 0; k < 200; k++) begin
            applyStimulus(1'b0, 1'b1, 6'd16, 4'd10);
            #2;
            if (bit_count == 4'd4 && edge_count == 6'd6) begin
                found = 1;
                break;
            end
        end
        checkOutput("abort_reached_point", found, 1);
        applyStimulus(1'b0, 1'b0, 6'd16, 4'd10);
        #2;
        checkOutput("abort_cycle_edge", edge_count, 7);
        checkOutput("abort_cycle_stb", sample_stb, 0);
        checkOutput("abort_cycle_frame_done", frame_done, 0);
        applyStimulus(1'b0, 1'b0, 6'd16, 4'd10);
        #2;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_edge", edge_count, 0);
        checkOutput("abort_bit", bit_count, 0);

        $display("[TB] illegal configuration");
        applyStimulus(1'b0, 1'b1, 6'd3, 4'd10);
        applyStimulus(1'b0, 1'b1, 6'd8, 4'd0);
        #2;
        checkOutput("illegal_p3_cfg_err", cfg_err, 1);
        checkOutput("illegal_p3_busy", busy, 0);
        applyStimulus(1'b0, 1'b1, 6'd4, 4'd3);
        #2;
        checkOutput("illegal_fb0_cfg_err", cfg_err, 1);
        checkOutput("illegal_fb0_busy", busy, 0);
        applyStimulus(1'b0, 1'b1, 6'd4, 4'd3);
        #2;
        checkOutput("legal_p4_cfg_err", cfg_err, 0);
        checkOutput("legal_p4_busy", busy, 1);
        for (int k = 0; k < 3; k++)
            applyStimulus(1'b0, 1'b1, 6'd4, 4'd3);
        #2;
        checkOutput("p4_edge3", edge_count, 3);
        checkOutput("p4_bit_done", bit_done, 1);
        checkOutput("p4_stb", sample_stb, 1);
        checkOutput("p4_idx", sample_idx, 2);
        runFrame(50, -1, 6'd0, 2, fd, nbd);
        checkOutput("p4_frame_done_rest", fd, 8);
        applyStimulus(1'b0, 1'b0, 6'd4, 4'd3);

        $display("[TB] reset mid-frame");
        applyStimulus(1'b0, 1'b1, 6'd8, 4'd10);
        found = 0;
        for (int k = 0; k < 200; k++) begin
            applyStimulus(1'b0, 1'b1, 6'd8, 4'd10);
            #2;
            if (bit_count == 4'd6) begin
                found = 1;
                break;
            end
        end
        checkOutput("rst_reached_bit6", found, 1);
        applyStimulus(1'b1, 1'b1, 6'd8, 4'd10);
        applyStimulus(1'b0, 1'b1, 6'd8, 4'd10);
        #2;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_edge", edge_count, 0);
        checkOutput("rst_bit", bit_count, 0);
        checkOutput("rst_bit_done", bit_done, 0);
        applyStimulus(1'b0, 1'b1, 6'd8, 4'd10);
        #2;
        checkOutput("rst_restart_busy", busy, 1);
        checkOutput("rst_restart_bit", bit_count, 0);
        runFrame(200, -1, 6'd0, 4, fd, nbd);
        checkOutput("rst_restart_frame_done", fd, 79);
        applyStimulus(1'b0, 1'b0, 6'd8, 4'd10);

        $display("[TB] randomized traffic");
        for (int k = 0; k < 3000; k++) begin
            applyStimulus(($urandom_range(0, 199) == 0),
                          ($urandom_range(0, 19) != 0),
                          6'($urandom_range(2, 12)),
                          4'($urandom_range(0, 4)));
        end
        applyStimulus(1'b0, 1'b0, 6'd8, 4'd10);
        applyStimulus(1'b0, 1'b0, 6'd8, 4'd10);
        #4;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
